// File: rtl/dma_s2mm_ctrl.sv
// AXI-Lite sequencer that programs one AXI DMA S2MM transfer,
// waits for the completion interrupt, clears it and checks status.
module dma_s2mm_ctrl #(
  parameter logic [31:0] DMACR_VAL   = 32'h0000_1001,
  parameter logic [31:0] IRQ_CLR_VAL = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dest_addr,
  input  logic [31:0] byte_num,
  input  logic        start,
  input  logic        s2mm_introut,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  m_axi_lite_awaddr,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready,
  output logic [9:0]  m_axi_lite_araddr,
  output logic        m_axi_lite_arvalid,
  input  logic        m_axi_lite_arready,
  input  logic [31:0] m_axi_lite_rdata,
  input  logic [1:0]  m_axi_lite_rresp,
  input  logic        m_axi_lite_rvalid,
  output logic        m_axi_lite_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, WAIT_IRQ, RD_REQ, RD_RESP, DONE
  } state_e;

  localparam logic [9:0] SR_ADDR = 10'h034;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [9:0]  awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [9:0]  araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        aw_ok, w_ok;
  logic        unused_rdata;

  assign unused_rdata = ^{m_axi_lite_rdata[31:7],
                          m_axi_lite_rdata[3:0]};

  // Register/value pair for each programming step
  function automatic logic [41:0] step_wr(
    input logic [2:0]  s,
    input logic [63:0] a,
    input logic [31:0] n
  );
    logic [41:0] r;
    r = {10'h030, DMACR_VAL};
    unique case (s)
      3'd0:    r = {10'h030, DMACR_VAL};
      3'd1:    r = {10'h048, a[31:0]};
      3'd2:    r = {10'h04C, a[63:32]};
      3'd3:    r = {10'h058, n};
      3'd4:    r = {10'h034, IRQ_CLR_VAL};
      default: r = {10'h030, DMACR_VAL};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    addr_d    = addr_q;
    len_d     = len_q;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    aw_ok     = ~awvalid_q | m_axi_lite_awready;
    w_ok      = ~wvalid_q | m_axi_lite_wready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (byte_num != 32'd0) begin
            addr_d  = dest_addr;
            len_d   = byte_num;
            err_d   = 1'b0;
            step_d  = 3'd0;
            state_d = WR_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_axi_lite_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_lite_wready) wvalid_d = 1'b0;
        if (aw_ok && w_ok) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_lite_bvalid) begin
          if (m_axi_lite_bresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (step_q == 3'd3) begin
            state_d = WAIT_IRQ;
          end else if (step_q == 3'd4) begin
            state_d = RD_REQ;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = WR_REQ;
          end
        end
      end
      WAIT_IRQ: begin
        if (s2mm_introut) begin
          step_d  = 3'd4;
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        if (m_axi_lite_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_lite_rvalid) begin
          if (m_axi_lite_rresp != 2'b00 ||
              m_axi_lite_rdata[6:4] != 3'd0)
            err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state
    if (state_d == WR_REQ && state_q != WR_REQ) begin
      awvalid_d             = 1'b1;
      wvalid_d              = 1'b1;
      {awaddr_d, wdata_d}   = step_wr(step_d, addr_d, len_d);
    end
    if (state_d == RD_REQ && state_q != RD_REQ) begin
      arvalid_d = 1'b1;
      araddr_d  = SR_ADDR;
    end
    bready_d = (state_d == WR_RESP);
    rready_d = (state_d == RD_RESP);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      addr_q    <= 64'd0;
      len_q     <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= 10'd0;
      wdata_q   <= 32'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= 10'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = err_q;
  assign m_axi_lite_awaddr  = awaddr_q;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;
  assign m_axi_lite_araddr  = araddr_q;
  assign m_axi_lite_arvalid = arvalid_q;
  assign m_axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_dma_s2mm_ctrl.sv
// Bench for dma_s2mm_ctrl: AXI-Lite slave model feeding a scoreboard
// of expected register writes, status read and completion.
module tb_dma_s2mm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] dest_addr = '0;
  logic [31:0] byte_num = '0;
  logic        start = 1'b0;
  logic        irq = 1'b0;
  logic        busy, done, error;
  logic [9:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;

  always #5 clk = ~clk;

  dma_s2mm_ctrl dut (
    .clk(clk), .rst(rst),
    .dest_addr(dest_addr), .byte_num(byte_num),
    .start(start), .s2mm_introut(irq),
    .busy(busy), .done(done), .error(error),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid),
    .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
    .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid),
    .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [9:0]  addr;
    logic [31:0] data;
  } txn_t;

  localparam logic [1:0] K_W = 2'd0;
  localparam logic [1:0] K_R = 2'd1;
  localparam logic [1:0] K_D = 2'd2;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int total = 0;
  int bad = 0;

  int          aw_dly = 0, w_dly = 0;
  logic [9:0]  err_addr = 10'h3FF;
  logic [31:0] rd_val = 32'h0000_1002;
  int          aw_cnt = 0, w_cnt = 0;
  int          n_aw = 0, n_w = 0, n_valid = 0;
  logic        have_aw = 0, have_w = 0;
  logic [9:0]  cap_a = '0;
  logic [31:0] cap_d = '0;
  logic        aw_hs_q = 0, w_hs_q = 0;
  logic        aw_st_q = 0, w_st_q = 0, ar_st_q = 0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid;
  assign rresp   = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Slave model: records every completed transaction
  always @(posedge clk) begin
    logic        ga, gw;
    logic [9:0]  a;
    logic [31:0] d;
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0;
      have_aw <= 0; have_w <= 0;
      bvalid <= 0; bresp <= 2'b00;
      rvalid <= 0; rdata <= '0;
      aw_hs_q <= 0; w_hs_q <= 0;
      aw_st_q <= 0; w_st_q <= 0; ar_st_q <= 0;
    end else begin
      ga = have_aw || (awvalid && awready);
      gw = have_w || (wvalid && wready);
      a  = (awvalid && awready) ? awaddr : cap_a;
      d  = (wvalid && wready) ? wdata : cap_d;
      aw_hs_q <= awvalid && awready;
      w_hs_q  <= wvalid && wready;
      aw_st_q <= awvalid && !awready;
      w_st_q  <= wvalid && !wready;
      ar_st_q <= arvalid && !arready;
      if (awvalid || wvalid || arvalid) n_valid <= n_valid + 1;
      if (awvalid && awready) begin
        n_aw <= n_aw + 1; aw_cnt <= 0;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        n_w <= n_w + 1; w_cnt <= 0;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) bvalid <= 0;
      if (ga && gw) begin
        obs_q.push_back('{K_W, a, d});
        have_aw <= 0; have_w <= 0;
        bvalid <= 1;
        bresp <= (a == err_addr) ? 2'b10 : 2'b00;
      end else begin
        have_aw <= ga; cap_a <= a;
        have_w <= gw; cap_d <= d;
      end
      if (rvalid && rready) rvalid <= 0;
      if (arvalid && arready) begin
        obs_q.push_back('{K_R, araddr, 32'd0});
        rvalid <= 1; rdata <= rd_val;
      end
      if (done) obs_q.push_back('{K_D, 10'd0, {31'd0, error}});
    end
  end

  // Monitor: pairs observed transactions with the expected queue
  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      txn_t o, e;
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_txn act=%h req=none", o);
      end else begin
        e = exp_q.pop_front();
        chk("txn", 64'(o), 64'(e));
      end
    end
    if (!rst) begin
      if (aw_hs_q) chk("awvalid_drop", 64'(awvalid), 64'd0);
      if (w_hs_q)  chk("wvalid_drop", 64'(wvalid), 64'd0);
      if (aw_st_q) chk("awvalid_hold", 64'(awvalid), 64'd1);
      if (w_st_q)  chk("wvalid_hold", 64'(wvalid), 64'd1);
      if (ar_st_q) chk("arvalid_hold", 64'(arvalid), 64'd1);
    end
  end

  task automatic pw(input logic [9:0] a, input logic [31:0] d);
    exp_q.push_back('{K_W, a, d});
  endtask

  task automatic pd(input logic e);
    exp_q.push_back('{K_D, 10'd0, {31'd0, e}});
  endtask

  task automatic push_full(input logic [63:0] a, input logic [31:0] n,
                           input logic e);
    pw(10'h030, 32'h0000_1001);
    pw(10'h048, a[31:0]);
    pw(10'h04C, a[63:32]);
    pw(10'h058, n);
    pw(10'h034, 32'h0000_1000);
    exp_q.push_back('{K_R, 10'h034, 32'd0});
    pd(e);
  endtask

  task automatic do_start(input logic [63:0] a, input logic [31:0] n);
    @(negedge clk);
    dest_addr = a; byte_num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout act=0 req=1");
    end
  endtask

  task automatic drain(input string nm);
    repeat (4) @(negedge clk);
    chk(nm, 64'(exp_q.size()), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, error, awvalid, wvalid, bready,
                arvalid, rready, awaddr, wdata, araddr});
  endfunction

  initial begin
    int c, b_aw, b_w, v0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", outs(), 64'd0);

    // Zero-wait slave, interrupt already high
    irq = 1'b1;
    pw(10'h030, 32'h0000_1001);
    pw(10'h048, 32'h8000_0000);
    pw(10'h04C, 32'h0000_0001);
    pw(10'h058, 32'h0000_1000);
    pw(10'h034, 32'h0000_1000);
    exp_q.push_back('{K_R, 10'h034, 32'd0});
    pd(1'b0);
    do_start(64'h0000_0001_8000_0000, 32'd4096);
    chk("t1_busy_early", 64'(busy), 64'd1);
    wait_done(c);
    chk("t1_latency", 64'(c), 64'd14);
    chk("t1_error", 64'(error), 64'd0);
    chk("t1_busy_done", 64'(busy), 64'd1);
    drain("t1_drained");

    // Slow wready, plus a stray start mid-transfer
    w_dly = 3;
    b_aw = n_aw; b_w = n_w;
    push_full(64'h0000_0002_0000_1000, 32'h200, 1'b0);
    do_start(64'h0000_0002_0000_1000, 32'h200);
    repeat (3) @(negedge clk);
    dest_addr = 64'hDEAD_BEEF_0000_0000; byte_num = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    chk("t2_error", 64'(error), 64'd0);
    drain("t2_drained");
    chk("t2_aw_count", 64'(n_aw - b_aw), 64'd5);
    chk("t2_w_count", 64'(n_w - b_w), 64'd5);
    w_dly = 0;

    // SLVERR on the DA_MSB write
    err_addr = 10'h04C;
    pw(10'h030, 32'h0000_1001);
    pw(10'h048, 32'h4000_0000);
    pw(10'h04C, 32'h0000_0003);
    pd(1'b1);
    do_start(64'h0000_0003_4000_0000, 32'd64);
    wait_done(c);
    chk("t3_error", 64'(error), 64'd1);
    @(negedge clk);
    chk("t3_busy_after", 64'(busy), 64'd0);
    drain("t3_drained");
    err_addr = 10'h3FF;

    // Zero-length request
    v0 = n_valid;
    pd(1'b1);
    do_start(64'h0000_0000_0000_1000, 32'd0);
    wait_done(c);
    chk("t4_latency", 64'(c), 64'd1);
    chk("t4_error", 64'(error), 64'd1);
    drain("t4_drained");
    chk("t4_no_valids", 64'(n_valid - v0), 64'd0);

    // Status readback with DMAIntErr
    rd_val = 32'h0000_1010;
    push_full(64'h0000_0000_0000_0010, 32'd8, 1'b1);
    do_start(64'h0000_0000_0000_0010, 32'd8);
    wait_done(c);
    chk("t5_latency", 64'(c), 64'd14);
    chk("t5_error", 64'(error), 64'd1);
    drain("t5_drained");
    rd_val = 32'h0000_1002;

    // Reset while waiting for the interrupt, then a clean run
    irq = 1'b0;
    pw(10'h030, 32'h0000_1001);
    pw(10'h048, 32'h0000_0100);
    pw(10'h04C, 32'h0000_0005);
    pw(10'h058, 32'h0000_0010);
    do_start(64'h0000_0005_0000_0100, 32'd16);
    repeat (12) @(negedge clk);
    chk("t6_wait_busy", 64'(busy), 64'd1);
    chk("t6_writes_seen", 64'(exp_q.size()), 64'd0);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset", outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    irq = 1'b1;
    push_full(64'h0000_0006_0000_0200, 32'd32, 1'b0);
    do_start(64'h0000_0006_0000_0200, 32'd32);
    wait_done(c);
    chk("t6_latency", 64'(c), 64'd14);
    chk("t6_error", 64'(error), 64'd0);
    drain("t6_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

endmodule
